// File: rtl/data_mem_slave.sv
// data_mem_slave: data-side memory responder behind the core's data-memory stage.
// Serves one outstanding word transaction at a time over a req/gnt/rvalid
// interface from an internal byte-enabled RAM. Grant and response latencies
// are parameterised so that upstream stall paths can be exercised.
//
// Ports:
//   clk            - clock, all state changes on rising edge
//   reset          - asynchronous active-low reset (RAM contents are kept)
//   data_req_i     - request from the data-memory stage
//   data_addr_i    - byte address (addr[1:0] ignored)
//   data_we_i      - 1 = write, 0 = read
//   data_be_i      - byte enables, lane i = bits [8i+7:8i] (writes only)
//   data_wdata_i   - lane-aligned write data
//   stall_inject_i - forces gnt low while high
//   data_gnt_o     - request accepted this cycle
//   data_rvalid_o  - one-cycle response strobe
//   data_rdata_o   - read data, valid with rvalid, otherwise 0
//   data_err_o     - out-of-range flag, valid with rvalid, otherwise 0
//   busy_o         - FSM is not IDLE
module data_mem_slave #(
  parameter int unsigned DEPTH_WORDS  = 1024,
  parameter logic [31:0] ADDR_BASE    = 32'h0000_0000,
  parameter int unsigned GNT_DELAY    = 0,
  parameter int unsigned RVALID_DELAY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_req_i,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  input  logic        stall_inject_i,
  output logic        data_gnt_o,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o,
  output logic        data_err_o,
  output logic        busy_o
);

  localparam int unsigned AW  = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  // A response delay of 0 is meaningless for a registered strobe; clamp to 1.
  localparam int unsigned RVD = (RVALID_DELAY < 1) ? 1 : RVALID_DELAY;

  typedef enum logic [1:0] {IDLE, GNT_WAIT, RESP_WAIT} state_e;

  state_e      state_q, state_d;
  logic [31:0] gcnt_q, gcnt_d;
  logic [31:0] rcnt_q, rcnt_d;
  logic        err_q, err_d;
  logic [31:0] lat_q, lat_d;
  logic        rvalid_q, rvalid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        erro_q, erro_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] off;
  logic        in_range;
  logic [AW-1:0] widx;
  logic        gnt;
  logic        unused_off;

  assign off        = data_addr_i - ADDR_BASE;
  assign in_range   = (data_addr_i >= ADDR_BASE) && ({2'b00, off[31:2]} < 32'(DEPTH_WORDS));
  assign widx       = off[AW+1:2];
  assign unused_off = ^off[1:0];

  always_comb begin
    state_d  = state_q;
    gcnt_d   = gcnt_q;
    rcnt_d   = rcnt_q;
    err_d    = err_q;
    lat_d    = lat_q;
    gnt      = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (data_req_i && !stall_inject_i) begin
          if (GNT_DELAY == 0) begin
            gnt = 1'b1;
          end else begin
            state_d = GNT_WAIT;
            gcnt_d  = 32'd1;
          end
        end
      end
      GNT_WAIT: begin
        if (!data_req_i) begin
          // Master withdrew the request: abandon it silently.
          state_d = IDLE;
          gcnt_d  = '0;
        end else if (!stall_inject_i) begin
          if (gcnt_q == 32'(GNT_DELAY)) gnt = 1'b1;
          else                          gcnt_d = gcnt_q + 32'd1;
        end
      end
      RESP_WAIT: begin
        if (rcnt_q == 32'(RVD)) begin
          state_d = IDLE;
          rcnt_d  = '0;
        end else begin
          rcnt_d = rcnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Grant edge: gnt is only ever raised with req high.
    if (gnt) begin
      state_d = RESP_WAIT;
      rcnt_d  = 32'd1;
      gcnt_d  = '0;
      err_d   = !in_range;
      lat_d   = (!data_we_i && in_range) ? mem[widx] : 32'h0;
    end

    // Strobe is registered from next-state so it lands RVD cycles after the grant edge.
    rvalid_d = (state_d == RESP_WAIT) && (rcnt_d == 32'(RVD));
    rdata_d  = rvalid_d ? lat_d : 32'h0;
    erro_d   = rvalid_d & err_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      gcnt_q   <= '0;
      rcnt_q   <= '0;
      err_q    <= 1'b0;
      lat_q    <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      erro_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      rcnt_q   <= rcnt_d;
      err_q    <= err_d;
      lat_q    <= lat_d;
      rvalid_q <= rvalid_d;
      rdata_q  <= rdata_d;
      erro_q   <= erro_d;
    end
  end

  // RAM has no reset so its contents survive a reset pulse.
  always_ff @(posedge clk) begin
    if (data_gnt_o && data_we_i && in_range) begin
      for (int i = 0; i < 4; i++) begin
        if (data_be_i[i]) mem[widx][8*i +: 8] <= data_wdata_i[8*i +: 8];
      end
    end
  end

  assign data_gnt_o    = gnt && reset;
  assign data_rvalid_o = rvalid_q;
  assign data_rdata_o  = rdata_q;
  assign data_err_o    = erro_q;
  assign busy_o        = (state_q != IDLE);

  // Protocol checks: one response per grant, never overlapping the grant.
  logic pend_q;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                          pend_q <= 1'b0;
    else if (data_gnt_o && data_req_i)   pend_q <= 1'b1;
    else if (data_rvalid_o)              pend_q <= 1'b0;
  end

  a_no_gnt_rvalid: assert property (@(posedge clk) disable iff (!reset)
    !(data_gnt_o && data_rvalid_o));
  a_rvalid_granted: assert property (@(posedge clk) disable iff (!reset)
    data_rvalid_o |-> pend_q);

endmodule

// File: doc/data_mem_slave.md
Name: data_mem_slave

Overview:
- Data-side memory responder that sits directly downstream of the core's data-memory stage.
- Consumes that stage's req/gnt/rvalid request interface and serves single-outstanding word transactions from an internal byte-enabled RAM.
- Grant and response latencies are configurable, so stall paths in the upstream FSM can be exercised.
- Flags out-of-range accesses with an error strobe.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words in the RAM.
- ADDR_BASE, 32'h00000000: byte address mapped to word 0.
- GNT_DELAY, 0: cycles req must be held before gnt is given (0 = gnt combinational in the same cycle).
- RVALID_DELAY, 1: cycles from the grant edge to the rvalid pulse (minimum 1).

Ports:
- clk  input  1  clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-low reset.
- data_req_i  input  1  request from the data-memory stage.
- data_addr_i  input  32  byte address.
- data_we_i  input  1  1 = write, 0 = read.
- data_be_i  input  4  byte enables; lane i = bits [8i+7:8i].
- data_wdata_i  input  32  write data, already lane-aligned by the master.
- stall_inject_i  input  1  verification hook; while 1, gnt is forced to 0.
- data_gnt_o  output  1  request accepted.
- data_rvalid_o  output  1  one-cycle response strobe.
- data_rdata_o  output  32  read data, valid with rvalid.
- data_err_o  output  1  out-of-range flag, valid with rvalid.
- busy_o  output  1  1 when state is not IDLE.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, counters=0.
  - data_rvalid_o=0, data_rdata_o=0, data_err_o=0, busy_o=0.
  - data_gnt_o=0 while reset is low.
  - RAM contents are NOT cleared.
  - Reset asserted mid-transaction abandons it: no rvalid is issued afterwards. A write already granted stays committed.
- Word index = (data_addr_i - ADDR_BASE) >> 2; addr[1:0] is ignored.
- In range iff data_addr_i >= ADDR_BASE and word index < DEPTH_WORDS.
- FSM states: IDLE, GNT_WAIT, RESP_WAIT. One transaction outstanding; no pipelining.
- IDLE:
  - With req=1 and stall_inject_i=0: if GNT_DELAY==0, gnt=1 combinationally and the grant edge occurs this cycle. Otherwise go to GNT_WAIT with gcnt=1.
  - With req=0: stay in IDLE.
- GNT_WAIT:
  - gcnt increments on each cycle with req=1 and stall_inject_i=0.
  - gnt=1 in the cycle gcnt==GNT_DELAY and stall_inject_i=0.
  - req dropping to 0 (protocol violation) returns the FSM to IDLE with no response.
- Grant edge (gnt=1 and req=1 at a rising clk):
  - Latch we and err.
  - In-range write: update each lane with be[i]=1; other lanes unchanged.
  - In-range read: latch the full RAM word (be is ignored for reads).
  - Out-of-range access: no write; latched read data = 0.
  - Go to RESP_WAIT with rcnt=1.
- RESP_WAIT:
  - gnt=0.
  - When rcnt==RVALID_DELAY, data_rvalid_o=1 for exactly one cycle. Registered output, so rvalid appears RVALID_DELAY cycles after the grant edge.
  - In that same cycle: data_rdata_o = latched word (0 for writes and for errors), data_err_o = latched err.
  - Then go to IDLE.
  - A req arriving in the rvalid cycle is not granted until the following cycle (IDLE).
- Outside the rvalid cycle, data_rdata_o and data_err_o return to 0.
- stall_inject_i=1 suppresses gnt in any state, extending GNT_WAIT or keeping IDLE from granting. It has no effect on a transaction already granted.
- busy_o=1 in GNT_WAIT and RESP_WAIT.
- Assertions:
  - Never gnt and rvalid in the same cycle.
  - Never more than one rvalid per grant.
  - Never rvalid without a prior grant since reset.

Test Plan:
- Defaults: SW at 0x10 with data 0xDEADBEEF, be=1111 -> gnt same cycle, rvalid 1 cycle later with rdata=0, err=0. Follow-up LW at 0x10 -> rvalid with rdata=0xDEADBEEF.
- Byte lanes: write 0x11223344 to 0x20, then wdata=0x0000AA00 with be=0010 -> a read of 0x20 returns 0x1122AA44. Then be=1100 with 0xBBCC0000 -> read returns 0xBBCCAA44.
- Latency: GNT_DELAY=2, RVALID_DELAY=3, req held -> gnt in the 3rd req cycle, rvalid exactly 3 cycles after the grant edge, busy_o high throughout.
- Stall inject: stall_inject_i=1 for 5 cycles with req held -> no gnt for those 5 cycles, gnt in the first cycle after release, correct response afterwards.
- Out of range: DEPTH_WORDS=1024, read of 0x00001000 -> rvalid with err=1 and rdata=0. Write to 0x00001000 -> err=1 and word 0 is unchanged.
- Reset mid-op: grant a LW, pull reset low before rvalid -> rvalid stays 0 and state returns to IDLE. After release, re-reading a previously written word returns the preserved value.
